// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults for the synchronous FIFO and its stream reader.
//   DATA_WIDTH/DEPTH/PTR_WIDTH : FIFO geometry
//   BURST_LEN/CNT_WIDTH        : reader framing and beat counter defaults
//   BUF_DEPTH                  : reader output buffer entries
//   next_beat()                : burst position counter with wrap
package fifo_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 16;
    localparam int PTR_WIDTH  = $clog2(DEPTH);
    localparam int BURST_LEN  = 4;
    localparam int CNT_WIDTH  = 16;
    localparam int BUF_DEPTH  = 2;

    function automatic logic [7:0] next_beat(input logic [7:0] cur, input logic [7:0] last);
        return (cur == last) ? 8'd0 : cur + 8'd1;
    endfunction
endpackage

// File: rtl/stream_buf2.sv
// stream_buf2: 2-entry in-order valid/ready queue.
//   clk, rst        : clock, synchronous active-high reset
//   push, push_data : write a word at the tail
//   pop             : remove the head word
//   occ             : entries held (0..2)
//   head_valid/data : oldest word
module stream_buf2 import fifo_pkg::*; #(
    parameter int DW = DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [1:0]    occ,
    output logic          head_valid,
    output logic [DW-1:0] head_data
);
    logic [DW-1:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]    occ_q, occ_d, rem;

    // rem is the occupancy left after the pop; the pushed word lands at slot rem
    always_comb begin
        rem    = occ_q - {1'b0, pop};
        occ_d  = rem + {1'b0, push};
        head_d = pop ? tail_q : head_q;
        tail_d = tail_q;
        if (push && rem == 2'd0) head_d = push_data;
        if (push && rem == 2'(BUF_DEPTH-1)) tail_d = push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign occ        = occ_q;
    assign head_valid = occ_q != 2'd0;
    assign head_data  = head_q;
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a FIFO read port onto a valid/ready stream in fixed bursts.
//   clk, rst            : clock, synchronous active-high reset
//   en                  : allow new FIFO reads
//   fifo_empty/data     : FIFO status and registered read data
//   fifo_rd_en          : FIFO read strobe (combinational)
//   m_valid/ready/data  : output stream
//   m_last              : final beat of each BURST_LEN burst
//   beat_count          : accepted beats, wrapping
module fifo_stream_reader import fifo_pkg::*; #(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int BURST_LEN  = fifo_pkg::BURST_LEN,
    parameter int CNT_WIDTH  = fifo_pkg::CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  beat_count
);
    localparam logic [7:0] LAST = 8'(BURST_LEN-1);

    logic                 rd_pend_q, rd_pend_d, pop;
    logic [7:0]           beat_cnt_q, beat_cnt_d;
    logic [CNT_WIDTH-1:0] beat_count_q, beat_count_d;
    logic [1:0]           occ;
    logic [2:0]           credit;

    stream_buf2 #(.DW(DATA_WIDTH)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_pend_q),
        .push_data (fifo_data),
        .pop       (pop),
        .occ       (occ),
        .head_valid(m_valid),
        .head_data (m_data)
    );

    // Counting this cycle's pop as freed space lets a full buffer keep reading
    // while the consumer drains it, which is what sustains one word per clock.
    always_comb begin
        pop          = m_valid && m_ready;
        credit       = {1'b0, occ} + {2'b0, rd_pend_q} - {2'b0, pop};
        fifo_rd_en   = !rst && en && !fifo_empty && credit < 3'd2;
        rd_pend_d    = fifo_rd_en;
        beat_cnt_d   = pop ? next_beat(beat_cnt_q, LAST) : beat_cnt_q;
        beat_count_d = beat_count_q + CNT_WIDTH'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q    <= 1'b0;
            beat_cnt_q   <= '0;
            beat_count_q <= '0;
        end else begin
            rd_pend_q    <= rd_pend_d;
            beat_cnt_q   <= beat_cnt_d;
            beat_count_q <= beat_count_d;
        end
    end

    assign m_last     = m_valid && beat_cnt_q == LAST;
    assign beat_count = beat_count_q;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: self-checking bench with a FIFO model and a data scoreboard.
module tb_fifo_stream_reader;
    localparam int BL = 4;

    logic        clk = 1'b0;
    logic        rst, en, fifo_empty, fifo_rd_en, m_valid, m_ready, m_last;
    logic [7:0]  fifo_data, m_data;
    logic [15:0] beat_count;

    fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(BL), .CNT_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd_en(fifo_rd_en),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rd;
        logic       v;
        logic [7:0] d;
        logic       l;
    } vec_t;

    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    int         errors = 0, checks = 0;
    int         reads = 0, outstanding = 0, tb_beat = 0, tb_cnt = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] prev_data = 8'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic preload(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fq.push_back(base + 8'(i));
            exp_q.push_back(base + 8'(i));
        end
        fifo_empty = (fq.size() == 0);
    endtask

    // One clock: check around the edge, then model the FIFO's registered read.
    task automatic step(input logic wr, input logic [7:0] wv);
        logic rd, pop;
        logic [7:0] e;
        #1;
        rd  = fifo_rd_en;
        pop = m_valid && m_ready && !rst;
        chk("rd_when_empty", {31'b0, fifo_rd_en && fifo_empty}, 0);
        if (!rst) chk("beat_count", {16'b0, beat_count}, tb_cnt & 32'hffff);
        if (stall_prev) begin
            chk("stall_valid", {31'b0, m_valid}, 1);
            chk("stall_data", {24'b0, m_data}, {24'b0, prev_data});
        end
        if (pop) begin
            if (exp_q.size() == 0) chk("unexpected_beat", {24'b0, m_data}, 32'hffffffff);
            else begin
                e = exp_q.pop_front();
                chk("sb_data", {24'b0, m_data}, {24'b0, e});
                chk("sb_last", {31'b0, m_last}, {31'b0, tb_beat == BL-1});
            end
            tb_beat = (tb_beat == BL-1) ? 0 : tb_beat + 1;
            tb_cnt++;
            outstanding--;
        end
        if (rd) begin
            reads++;
            outstanding++;
        end
        stall_prev = m_valid && !m_ready && !rst;
        prev_data  = m_data;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < outstanding && exp_q.size() > 0; i++) void'(exp_q.pop_front());
            outstanding = 0;
            tb_beat     = 0;
            tb_cnt      = 0;
            stall_prev  = 1'b0;
        end
        #1;
        if (rd && fq.size() > 0) fifo_data = fq.pop_front();
        if (wr) begin
            fq.push_back(wv);
            exp_q.push_back(wv);
        end
        fifo_empty = (fq.size() == 0);
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && (exp_q.size() > 0 || m_valid === 1'b1); i++) step(1'b0, 8'h0);
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        vec_t tbl[11];
        int   r0, b0, k;
        tbl[0]  = '{1, 0, 8'h00, 0};
        tbl[1]  = '{1, 0, 8'h00, 0};
        tbl[2]  = '{1, 1, 8'h11, 0};
        tbl[3]  = '{1, 1, 8'h12, 0};
        tbl[4]  = '{1, 1, 8'h13, 0};
        tbl[5]  = '{1, 1, 8'h14, 1};
        tbl[6]  = '{1, 1, 8'h15, 0};
        tbl[7]  = '{1, 1, 8'h16, 0};
        tbl[8]  = '{0, 1, 8'h17, 0};
        tbl[9]  = '{0, 1, 8'h18, 1};
        tbl[10] = '{0, 0, 8'h00, 0};

        rst = 1'b1; en = 1'b1; m_ready = 1'b0; fifo_empty = 1'b1; fifo_data = 8'h0;
        @(negedge clk);
        // Reset held with FIFO data present
        preload(8'h11, 4);
        step(1'b0, 8'h0);
        step(1'b0, 8'h0);
        #1;
        chk("rst_rd_en", {31'b0, fifo_rd_en}, 0);
        chk("rst_valid", {31'b0, m_valid}, 0);
        chk("rst_data", {24'b0, m_data}, 0);
        chk("rst_count", {16'b0, beat_count}, 0);
        rst = 1'b0; m_ready = 1'b1;
        drain("drain_reset");

        // Streaming, table-driven per cycle
        preload(8'h11, 8);
        b0 = tb_cnt;
        for (int i = 0; i < 11; i++) begin
            #1;
            chk("tbl_rd_en", {31'b0, fifo_rd_en}, {31'b0, tbl[i].rd});
            chk("tbl_valid", {31'b0, m_valid}, {31'b0, tbl[i].v});
            if (tbl[i].v) begin
                chk("tbl_data", {24'b0, m_data}, {24'b0, tbl[i].d});
                chk("tbl_last", {31'b0, m_last}, {31'b0, tbl[i].l});
            end
            step(1'b0, 8'h0);
        end
        chk("stream_beats", tb_cnt - b0, 8);

        // Backpressure
        m_ready = 1'b0;
        preload(8'h11, 8);
        r0 = reads;
        for (int i = 0; i < 6; i++) step(1'b0, 8'h0);
        #1;
        chk("bp_reads", reads - r0, 2);
        chk("bp_rd_en", {31'b0, fifo_rd_en}, 0);
        chk("bp_valid", {31'b0, m_valid}, 1);
        chk("bp_data", {24'b0, m_data}, 32'h11);
        m_ready = 1'b1;
        drain("drain_bp");
        chk("bp_reads_total", reads - r0, 8);

        // Sparse writes into an otherwise empty FIFO
        for (int i = 0; i < 24; i++) step(i % 3 == 0, 8'h21 + 8'(i / 3));
        drain("drain_sparse");

        // en gating after three reads
        preload(8'h11, 8);
        b0 = tb_cnt;
        for (int i = 0; i < 3; i++) step(1'b0, 8'h0);
        en = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b0, 8'h0);
        #1;
        chk("en_beats", tb_cnt - b0, 3);
        chk("en_valid", {31'b0, m_valid}, 0);
        en = 1'b1;
        k = 0;
        while (k < 10 && m_valid !== 1'b1) begin
            step(1'b0, 8'h0);
            k++;
        end
        #1;
        chk("en_resume_data", {24'b0, m_data}, 32'h14);
        chk("en_resume_last", {31'b0, m_last}, 1);
        drain("drain_en");

        // Reset mid-burst: 0x11,0x12 accepted, 0x13 buffered, 0x14 in flight
        preload(8'h11, 8);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h0);
        rst = 1'b1; m_ready = 1'b0;
        step(1'b0, 8'h0);
        rst = 1'b0;
        #1;
        chk("mid_rst_count", {16'b0, beat_count}, 0);
        chk("mid_rst_valid", {31'b0, m_valid}, 0);
        chk("mid_rst_next", exp_q.size() > 0 ? {24'b0, exp_q[0]} : 32'h0, 32'h15);
        m_ready = 1'b1;
        drain("drain_mid_rst");
        chk("mid_rst_beats", tb_cnt, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
